// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmitter signal bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
    parameter int NREQ = 2,
    parameter int SIZE = 32
);
    logic [NREQ-1:0]      req;
    logic [NREQ*SIZE-1:0] data;
    logic [NREQ-1:0]      ack;
    logic                 busy;
    logic                 done;
    logic                 tx_dv;
    logic [7:0]           tx_byte;
    logic                 tx_active;
    logic                 tx_done;

    // Arbiter side: drives grants and the transmitter strobe.
    modport master (
        input  req, data, tx_active, tx_done,
        output ack, busy, done, tx_dv, tx_byte
    );

    // Environment side: requesters and the byte transmitter.
    modport slave (
        output req, data, tx_active, tx_done,
        input  ack, busy, done, tx_dv, tx_byte
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin word arbiter feeding one byte-level UART transmitter
module uart_tx_arbiter #(
    parameter int NREQ   = 2,
    parameter int SIZE   = 32,
    parameter int HEADER = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.master bus
);
    localparam int NB  = SIZE / 8 + HEADER;
    localparam int RW  = $clog2(NB + 1);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tx_dv_q, tx_dv_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic [SIZE-1:0]   shift_q, shift_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [IDW-1:0]    last_q, last_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic              hdr_q, hdr_d;

    logic [SIZE-1:0]   words [NREQ];
    logic [IDW-1:0]    grant;
    logic [IDW-1:0]    cand;
    logic              found;
    logic [3:0]        id4;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_words
        assign words[gi] = bus.data[gi*SIZE +: SIZE];
    end

    // Round-robin search starting just after the last requester served.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDW'((int'(last_q) + i) % NREQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    // Requester id zero-extended into the low nibble of the header byte.
    always_comb begin
        id4 = '0;
        id4[IDW-1:0] = id_q;
    end

    // Next-state and registered-output logic; one byte outstanding at a time.
    always_comb begin
        state_d   = state_q;
        ack_d     = '0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        shift_d   = shift_q;
        id_d      = id_q;
        last_d    = last_q;
        rem_d     = rem_q;
        hdr_d     = hdr_q;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (found && !bus.tx_active) begin
                    ack_d[grant] = 1'b1;
                    busy_d       = 1'b1;
                    id_d         = grant;
                    shift_d      = words[grant];
                    rem_d        = RW'(NB);
                    hdr_d        = (HEADER != 0);
                    state_d      = S_SEND;
                end
            end
            S_SEND: begin
                tx_dv_d   = 1'b1;
                tx_byte_d = hdr_q ? {4'hA, id4} : shift_q[7:0];
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (bus.tx_done) begin
                    if (rem_q > RW'(1)) begin
                        rem_d = rem_q - RW'(1);
                        if (hdr_q) begin
                            hdr_d = 1'b0;
                        end else begin
                            shift_d = shift_q >> 8;
                        end
                        state_d = S_SEND;
                    end else begin
                        done_d  = 1'b1;
                        last_d  = id_q;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset leaves requester 0 as first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ack_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            shift_q   <= '0;
            id_q      <= '0;
            last_q    <= IDW'(NREQ - 1);
            rem_q     <= '0;
            hdr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            shift_q   <= shift_d;
            id_q      <= id_d;
            last_q    <= last_d;
            rem_q     <= rem_d;
            hdr_q     <= hdr_d;
        end
    end

    assign bus.ack     = ack_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.tx_dv   = tx_dv_q;
    assign bus.tx_byte = tx_byte_q;
endmodule
